turn_signal_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the tail-light sequencer.
- Synchronises and debounces the raw left, right and hazard switches.
- Encodes them into the sequencer's (hazard, left, right) request convention.
- Generates a one-cycle step enable that paces the light animation.

---
 rtl/turn_signal_input_conditioner.sv | 122 ++++++++++++
 tb/tb_turn_signal_input_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : turn_signal_input_conditioner
// Description : Synchronises and debounces the raw left/right/hazard switches,
//               encodes them into the tail-light sequencer's (hazard, left,
//               right) request code and generates the animation step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_signal_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_DIV        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_hazard,
  output logic hazard,
  output logic left,
  output logic right,
  output logic step
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int c_ST_W = $clog2(STEP_DIV);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_ST_W-1:0] c_ST_LAST = c_ST_W'(STEP_DIV - 1);

  // Bit order for the per-switch vectors: 0 = left, 1 = right, 2 = hazard.
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_db;

  logic [2:0] w_code;
  logic [2:0] r_code;

  logic [c_ST_W-1:0] r_step_cnt;
  logic              r_step;

  assign w_raw = {sw_hazard, sw_right, sw_left};

  // Two-flop synchroniser for all three asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [c_DB_W-1:0] r_cnt;
      logic              r_db;

      // Accept a new level only after it has differed from the current one
      // for DEBOUNCE_CYCLES consecutive synchronised cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync2[gi] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_db;
    end
  endgenerate

  // Both turn switches together are treated as a hazard request, so only
  // the codes 000, 010, 011 and 100 can ever be produced.
  always_comb begin
    w_code    = 3'b000;
    w_code[2] = w_db[2] | (w_db[0] & w_db[1]);
    w_code[1] = ~w_code[2] & (w_db[0] | w_db[1]);
    w_code[0] = ~w_code[2] & w_db[1];
  end

  // Encoded request register, one edge behind the debounced levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code <= 3'b000;
    end else begin
      r_code <= w_code;
    end
  end

  // Free-running step divider; a change of request code restarts the period
  // so a new pattern always begins with a full step interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else if (w_code != r_code) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else if (r_step_cnt == c_ST_LAST) begin
      r_step_cnt <= '0;
      r_step     <= 1'b1;
    end else begin
      r_step_cnt <= r_step_cnt + 1'b1;
      r_step     <= 1'b0;
    end
  end

  assign hazard = r_code[2];
  assign left   = r_code[1];
  assign right  = r_code[0];
  assign step   = r_step;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_signal_input_conditioner
// Description : Directed self-checking bench for the turn-signal input
//               conditioner (defaults DEBOUNCE_CYCLES=4, STEP_DIV=8).
//               "Edge e" is the e-th rising edge after the last reset edge;
//               inputs set before a tick are sampled on that tick's edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_signal_input_conditioner;

  logic clk;
  logic reset;
  logic sw_left;
  logic sw_right;
  logic sw_hazard;
  logic hazard;
  logic left;
  logic right;
  logic step;
  logic [2:0] code;

  int tests_run;
  int tests_failed;

  turn_signal_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_left(sw_left),
    .sw_right(sw_right),
    .sw_hazard(sw_hazard),
    .hazard(hazard),
    .left(left),
    .right(right),
    .step(step)
  );

  assign code = {hazard, left, right};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for three edges with all switches released.
  task automatic do_reset();
    reset     = 1'b1;
    sw_left   = 1'b0;
    sw_right  = 1'b0;
    sw_hazard = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    sw_left   = 1'b0;
    sw_right  = 1'b0;
    sw_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (code !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_code cycle %0d: got %b expected 000", i, code);
      end
      tests_run++;
      if (step !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_step cycle %0d: got %b expected 0", i, step);
      end
    end
    reset = 1'b0;
  endtask

  // Continues straight from test_reset: idle stepping, then a clean left.
  task automatic test_step_and_left();
    logic [2:0] exp_code;
    logic       exp_step;
    for (int e = 1; e <= 30; e++) begin
      sw_left = (e >= 11);
      tick();
      exp_code = (e >= 17) ? 3'b010 : 3'b000;
      exp_step = (e == 8) || (e == 16) || (e == 25);
      tests_run++;
      if (code !== exp_code) begin
        tests_failed++;
        $display("FAIL left_code edge %0d: got %b expected %b", e, code, exp_code);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL left_step edge %0d: got %b expected %b", e, step, exp_step);
      end
    end
  endtask

  // Right switch: high 2, low 1, then steady high.
  task automatic test_bounce();
    logic [2:0] exp_code;
    logic       exp_step;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      sw_right = (e != 3);
      tick();
      exp_code = (e >= 10) ? 3'b011 : 3'b000;
      exp_step = (e == 8) || (e == 18);
      tests_run++;
      if (code !== exp_code) begin
        tests_failed++;
        $display("FAIL bounce_code edge %0d: got %b expected %b", e, code, exp_code);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL bounce_step edge %0d: got %b expected %b", e, step, exp_step);
      end
    end
  endtask

  // Both turn switches -> hazard; dropping left leaves a right turn.
  task automatic test_both_then_release();
    logic [2:0] exp_code;
    logic       exp_step;
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      sw_right = 1'b1;
      sw_left  = (e <= 12);
      tick();
      exp_code = (e < 7) ? 3'b000 : ((e < 19) ? 3'b100 : 3'b011);
      exp_step = (e == 15) || (e == 27);
      tests_run++;
      if (code !== exp_code) begin
        tests_failed++;
        $display("FAIL both_code edge %0d: got %b expected %b", e, code, exp_code);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL both_step edge %0d: got %b expected %b", e, step, exp_step);
      end
    end
  endtask

  // Hazard held while left toggles every 3 cycles.
  task automatic test_hazard_toggle();
    logic [2:0] exp_code;
    logic       exp_step;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      sw_hazard = 1'b1;
      sw_left   = (((e - 1) / 3) % 2) == 1;
      tick();
      exp_code = (e < 7) ? 3'b000 : 3'b100;
      exp_step = (e >= 15) && (((e - 7) % 8) == 0);
      tests_run++;
      if (code !== exp_code) begin
        tests_failed++;
        $display("FAIL hazard_code edge %0d: got %b expected %b", e, code, exp_code);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL hazard_step edge %0d: got %b expected %b", e, step, exp_step);
      end
    end
    sw_hazard = 1'b0;
  endtask

  // Reset pulse at edge 12 while right is mid-debounce and left is active.
  task automatic test_reset_mid();
    logic [2:0] exp_code;
    logic       exp_step;
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      sw_left  = 1'b1;
      sw_right = (e >= 10);
      reset    = (e == 12);
      tick();
      if (e < 7)       exp_code = 3'b000;
      else if (e < 12) exp_code = 3'b010;
      else if (e < 19) exp_code = 3'b000;
      else             exp_code = 3'b100;
      exp_step = (e == 27);
      tests_run++;
      if (code !== exp_code) begin
        tests_failed++;
        $display("FAIL rstmid_code edge %0d: got %b expected %b", e, code, exp_code);
      end
      tests_run++;
      if (step !== exp_step) begin
        tests_failed++;
        $display("FAIL rstmid_step edge %0d: got %b expected %b", e, step, exp_step);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    sw_left      = 1'b0;
    sw_right     = 1'b0;
    sw_hazard    = 1'b0;
    test_reset();
    test_step_and_left();
    test_bounce();
    test_both_then_release();
    test_hazard_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
